issue_sequencer: RTL and testbench

Sits between instruction fetch and the dual-slot control/datapath (2 ALUs, 4-read/2-write register file). It accepts 32-bit fetch packets holding one or two 16-bit instructions, and issues them to slot 1 and slot 2. It serialises a packet when slot 2 depends on slot 1, adds the second cycle for extended instructions (LDA, BEQ), and tells the PC logic how far to advance.

---
 rtl/issue_sequencer_if.sv | 59 +++++
 rtl/issue_sequencer.sv | 169 ++++++++++++++++
 tb/tb_issue_sequencer.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/issue_sequencer_if.sv
// -----------------------------------------------------------------------------
// issue_sequencer_if
// Bundles the fetch handshake, the datapath hold/branch inputs and the two
// issue slots of the dual-issue sequencer.
//   master : fetch/datapath side (drives packet, valid, stall, branch result)
//   slave  : the sequencer (drives ready, issue slots, PC advance)
// Signals:
//   iFetchPacket  32-bit packet, slot 1 = [15:0], slot 2 = [31:16]
//   iFetchValid   packet available
//   oFetchReady   sequencer accepts a packet this cycle
//   iStall        datapath hold, freezes the sequencer
//   iBranchTaken  BEQ condition result (only looked at in the extension cycle)
//   oIssue1*/oIssue2*  per-slot valid, opcode, RegA, RegB, B-immediate flag
//   oExt1         slot 1 is in its extension (second) cycle
//   oPcAdvance    one-cycle pulse when a packet retires sequentially
//   oPcStep       halfwords to add to the PC, qualified by oPcAdvance
// -----------------------------------------------------------------------------
interface issue_sequencer_if #(
    parameter int OPW  = 4,
    parameter int REGW = 5
);
    logic [31:0]     iFetchPacket;
    logic            iFetchValid;
    logic            oFetchReady;
    logic            iStall;
    logic            iBranchTaken;

    logic            oIssue1Valid;
    logic [OPW-1:0]  oIssue1Op;
    logic [REGW-1:0] oIssue1RegA;
    logic [REGW-1:0] oIssue1RegB;
    logic            oIssue1BImm;
    logic            oExt1;

    logic            oIssue2Valid;
    logic [OPW-1:0]  oIssue2Op;
    logic [REGW-1:0] oIssue2RegA;
    logic [REGW-1:0] oIssue2RegB;
    logic            oIssue2BImm;

    logic            oPcAdvance;
    logic [1:0]      oPcStep;

    modport master (
        output iFetchPacket, iFetchValid, iStall, iBranchTaken,
        input  oFetchReady,
        input  oIssue1Valid, oIssue1Op, oIssue1RegA, oIssue1RegB, oIssue1BImm, oExt1,
        input  oIssue2Valid, oIssue2Op, oIssue2RegA, oIssue2RegB, oIssue2BImm,
        input  oPcAdvance, oPcStep
    );

    modport slave (
        input  iFetchPacket, iFetchValid, iStall, iBranchTaken,
        output oFetchReady,
        output oIssue1Valid, oIssue1Op, oIssue1RegA, oIssue1RegB, oIssue1BImm, oExt1,
        output oIssue2Valid, oIssue2Op, oIssue2RegA, oIssue2RegB, oIssue2BImm,
        output oPcAdvance, oPcStep
    );
endinterface

// File: rtl/issue_sequencer.sv
// -----------------------------------------------------------------------------
// issue_sequencer
// Takes 32-bit fetch packets holding one or two 16-bit instructions and issues
// them to the two datapath slots. A packet is split over two cycles when slot 2
// reads the register slot 1 writes, slot 1 LDA/BEQ get an extension cycle, and
// the PC logic is told how many halfwords a sequentially retired packet covers.
// Ports:
//   iClk  clock
//   iRst  synchronous active-high reset; all outputs are 0 while it is high
//   bus   issue_sequencer_if.slave (fetch handshake, stall, branch, issue slots,
//         PC advance)
// -----------------------------------------------------------------------------
module issue_sequencer #(
    parameter int OPW  = 4,
    parameter int REGW = 5
) (
    input  logic              iClk,
    input  logic              iRst,
    issue_sequencer_if.slave  bus
);
    localparam int S2 = 16;  // bit offset of slot 2 inside the packet

    localparam logic [OPW-1:0] OP_NOP  = OPW'(4'h0);
    localparam logic [OPW-1:0] OP_ADDR = OPW'(4'h1);
    localparam logic [OPW-1:0] OP_MVI  = OPW'(4'h7);
    localparam logic [OPW-1:0] OP_LDA  = OPW'(4'h9);
    localparam logic [OPW-1:0] OP_POP  = OPW'(4'hC);
    localparam logic [OPW-1:0] OP_JMP  = OPW'(4'hE);
    localparam logic [OPW-1:0] OP_BEQ  = OPW'(4'hF);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_FULL,
        S_EXT,
        S_SECOND
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [31:0]     r_pkt;

    logic [OPW-1:0]  w_op1, w_op2;
    logic [REGW-1:0] w_regA1, w_regB1, w_regA2, w_regB2;
    logic            w_bimm1, w_bimm2;
    logic            w_dual;
    logic            w_unused_pkt31;
    logic            w_wr1, w_rdA2, w_rdB2, w_hazard, w_extOp;

    logic            w_ready, w_iss1, w_iss2, w_ext, w_adv, w_retire;
    logic [1:0]      w_step;
    logic            w_accept;

    // Field extraction from the resident packet
    assign w_op1   = r_pkt[OPW-1:0];
    assign w_regA1 = r_pkt[OPW +: REGW];
    assign w_regB1 = r_pkt[OPW+REGW +: REGW];
    assign w_bimm1 = r_pkt[OPW+2*REGW];
    assign w_dual  = r_pkt[15];
    assign w_op2   = r_pkt[S2 +: OPW];
    assign w_regA2 = r_pkt[S2+OPW +: REGW];
    assign w_regB2 = r_pkt[S2+OPW+REGW +: REGW];
    assign w_bimm2 = r_pkt[S2+OPW+2*REGW];
    assign w_unused_pkt31 = r_pkt[31];  // top bit of slot 2 carries no meaning

    // Slot 1 writes RegA for ADDR..LDA and POP
    assign w_wr1    = ((w_op1 >= OP_ADDR) && (w_op1 <= OP_LDA)) || (w_op1 == OP_POP);
    // NOP, MVI and JMP in slot 2 read no registers
    assign w_rdA2   = !((w_op2 == OP_NOP) || (w_op2 == OP_MVI) || (w_op2 == OP_JMP));
    assign w_rdB2   = w_rdA2 && !w_bimm2;
    assign w_hazard = w_dual && w_wr1 &&
                      ((w_rdA2 && (w_regA2 == w_regA1)) || (w_rdB2 && (w_regB2 == w_regA1)));
    // Only slot 1 gets the extension cycle; slot 2 LDA/BEQ issue like a NOP
    assign w_extOp  = (w_op1 == OP_LDA) || (w_op1 == OP_BEQ);

    always_comb begin
        w_next   = r_state;
        w_ready  = 1'b0;
        w_iss1   = 1'b0;
        w_iss2   = 1'b0;
        w_ext    = 1'b0;
        w_adv    = 1'b0;
        w_retire = 1'b0;
        w_step   = 2'd0;
        // Reset and stall both leave every control output low and the state put
        if (!iRst && !bus.iStall) begin
            case (r_state)
                S_EMPTY: begin
                    w_ready = 1'b1;
                    if (bus.iFetchValid) begin
                        w_next = S_FULL;
                    end
                end
                S_FULL: begin
                    w_iss1 = 1'b1;
                    if (w_extOp) begin
                        w_next = S_EXT;
                    end else if (w_op1 == OP_JMP) begin
                        w_retire = 1'b1;  // slot 2 dropped, PC redirected elsewhere
                    end else if (w_hazard) begin
                        w_next = S_SECOND;
                    end else begin
                        w_iss2   = w_dual;
                        w_retire = 1'b1;
                        w_adv    = 1'b1;
                    end
                end
                S_EXT: begin
                    w_ext = 1'b1;
                    if ((w_op1 == OP_BEQ) && bus.iBranchTaken) begin
                        w_retire = 1'b1;  // taken branch: slot 2 dropped, no advance
                    end else if (w_dual) begin
                        w_next = S_SECOND;
                    end else begin
                        w_retire = 1'b1;
                        w_adv    = 1'b1;
                    end
                end
                S_SECOND: begin
                    w_iss2   = 1'b1;
                    w_retire = 1'b1;
                    w_adv    = 1'b1;
                end
                default: begin
                    w_next = S_EMPTY;
                end
            endcase
            // Retiring frees the packet register, so the next packet can load
            // on the same edge and issue without a bubble.
            if (w_retire) begin
                w_ready = 1'b1;
                w_next  = bus.iFetchValid ? S_FULL : S_EMPTY;
            end
            if (w_adv) begin
                w_step = w_dual ? 2'd2 : 2'd1;
            end
        end
    end

    assign w_accept = w_ready && bus.iFetchValid;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state <= S_EMPTY;
            r_pkt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_pkt <= bus.iFetchPacket;
            end
        end
    end

    assign bus.oFetchReady  = w_ready;
    assign bus.oIssue1Valid = w_iss1;
    assign bus.oIssue2Valid = w_iss2;
    assign bus.oExt1        = w_ext;
    assign bus.oPcAdvance   = w_adv;
    assign bus.oPcStep      = w_step;

    // Issue fields follow the packet register but read as 0 during reset
    assign bus.oIssue1Op    = iRst ? '0 : w_op1;
    assign bus.oIssue1RegA  = iRst ? '0 : w_regA1;
    assign bus.oIssue1RegB  = iRst ? '0 : w_regB1;
    assign bus.oIssue1BImm  = iRst ? 1'b0 : w_bimm1;
    assign bus.oIssue2Op    = iRst ? '0 : w_op2;
    assign bus.oIssue2RegA  = iRst ? '0 : w_regA2;
    assign bus.oIssue2RegB  = iRst ? '0 : w_regB2;
    assign bus.oIssue2BImm  = iRst ? 1'b0 : w_bimm2;
endmodule

// File: tb/tb_issue_sequencer.sv
`timescale 1ns/1ps
module tb_issue_sequencer;
    logic iClk = 1'b0;
    logic iRst;
    always #5 iClk = ~iClk;

    issue_sequencer_if #(.OPW(4), .REGW(5)) sif();
    issue_sequencer #(.OPW(4), .REGW(5)) dut (.iClk(iClk), .iRst(iRst), .bus(sif));

    // Stall / branch drive: directed values or per-cycle random values
    logic dir_stall, dir_taken, rnd_en, r_stall, r_taken;
    assign sif.iStall       = rnd_en ? r_stall : dir_stall;
    assign sif.iBranchTaken = rnd_en ? r_taken : dir_taken;

    typedef struct { logic [31:0] pkt; int avail; } ent_t;
    typedef struct packed { logic i1; logic e1; logic i2; logic adv; logic [1:0] step; } rec_t;

    ent_t        exp_q[$];   // accepted packets awaiting issue
    rec_t        lst[$];     // expected per-cycle behaviour of the resident packet
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [31:0] cur_pkt;
    bit          cur_valid;
    int          k;

    always @(posedge iClk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: actual=%h required=%h", name, cyc, act, req);
        end
    endfunction

    function automatic rec_t mk(input logic i1, input logic e1, input logic i2, input logic adv, input logic [1:0] st);
        rec_t r;
        r.i1 = i1; r.e1 = e1; r.i2 = i2; r.adv = adv; r.step = st;
        return r;
    endfunction

    // Reference model: the cycle-by-cycle issue sequence a packet produces
    task automatic build(input logic [31:0] p, input bit taken);
        logic [3:0] op1, op2;
        logic dual, wr1, rdA, rdB, haz;
        op1  = p[3:0];
        op2  = p[19:16];
        dual = p[15];
        wr1  = (op1 >= 4'd1 && op1 <= 4'd9) || op1 == 4'hC;
        rdA  = !(op2 == 4'h0 || op2 == 4'h7 || op2 == 4'hE);
        rdB  = rdA && !p[30];
        haz  = dual && wr1 && ((rdA && p[24:20] == p[8:4]) || (rdB && p[29:25] == p[8:4]));
        lst.delete();
        if (op1 == 4'h9 || op1 == 4'hF) begin
            lst.push_back(mk(1, 0, 0, 0, 2'd0));
            if (op1 == 4'hF && taken) lst.push_back(mk(0, 1, 0, 0, 2'd0));
            else if (dual) begin
                lst.push_back(mk(0, 1, 0, 0, 2'd0));
                lst.push_back(mk(0, 0, 1, 1, 2'd2));
            end else lst.push_back(mk(0, 1, 0, 1, 2'd1));
        end else if (op1 == 4'hE) begin
            lst.push_back(mk(1, 0, 0, 0, 2'd0));
        end else if (haz) begin
            lst.push_back(mk(1, 0, 0, 0, 2'd0));
            lst.push_back(mk(0, 0, 1, 1, 2'd2));
        end else begin
            lst.push_back(mk(1, 0, dual, 1, dual ? 2'd2 : 2'd1));
        end
    endtask

    // Monitor / scoreboard
    initial begin : chk_proc
        ent_t en;
        rec_t e;
        logic last;
        logic [6:0] act_c, exp_c;
        logic [36:0] allout;
        cur_valid = 0;
        k = 0;
        forever begin
            @(negedge iClk);
            act_c = {sif.oIssue1Valid, sif.oExt1, sif.oIssue2Valid, sif.oPcAdvance, sif.oPcStep, sif.oFetchReady};
            if (iRst) begin
                allout = {sif.oFetchReady, sif.oIssue1Valid, sif.oIssue1Op, sif.oIssue1RegA, sif.oIssue1RegB,
                          sif.oIssue1BImm, sif.oExt1, sif.oIssue2Valid, sif.oIssue2Op, sif.oIssue2RegA,
                          sif.oIssue2RegB, sif.oIssue2BImm, sif.oPcAdvance, sif.oPcStep};
                chk("reset_outputs", {27'd0, allout}, 64'd0);
                cur_valid = 0;
                exp_q.delete();
            end else begin
                if (!cur_valid && exp_q.size() > 0 && exp_q[0].avail <= cyc) begin
                    en = exp_q.pop_front();
                    cur_pkt = en.pkt;
                    build(cur_pkt, 1'b0);
                    k = 0;
                    cur_valid = 1;
                end
                if (cur_valid && k == 1 && cur_pkt[3:0] == 4'hF) build(cur_pkt, sif.iBranchTaken);
                e = cur_valid ? lst[k] : '0;
                last = !cur_valid || (k == lst.size() - 1);
                exp_c = sif.iStall ? 7'd0 : {e, last};
                chk(sif.iStall ? "stalled_ctl" : "issue_ctl", {57'd0, act_c}, {57'd0, exp_c});
                if (cur_valid)
                    chk("issue_fields",
                        {34'd0, sif.oIssue2BImm, sif.oIssue2RegB, sif.oIssue2RegA, sif.oIssue2Op,
                         sif.oIssue1BImm, sif.oIssue1RegB, sif.oIssue1RegA, sif.oIssue1Op},
                        {34'd0, cur_pkt[30:16], cur_pkt[14:0]});
                if (!sif.iStall && cur_valid) begin
                    k++;
                    if (k >= lst.size()) cur_valid = 0;
                end
            end
        end
    end

    // Random stall / branch-result generator
    initial begin
        r_stall = 0;
        r_taken = 0;
        forever begin
            @(posedge iClk);
            #1;
            r_stall = ($urandom_range(0, 4) == 0);
            r_taken = $urandom_range(0, 1) == 1;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge iClk);
        #1;
    endtask

    // Present a packet until accepted; the expectation is queued on acceptance
    task automatic offer(input logic [31:0] p);
        bit done;
        ent_t en;
        done = 0;
        sif.iFetchPacket = p;
        sif.iFetchValid = 1;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge iClk);
            if (sif.oFetchReady === 1'b1 && !iRst) begin
                en.pkt = p;
                en.avail = cyc + 1;
                exp_q.push_back(en);
                done = 1;
            end
            @(posedge iClk);
            #1;
        end
        sif.iFetchValid = 0;
        if (!done) begin
            n_chk++;
            n_fail++;
            $display("FAIL offer_timeout: packet %h accepted=0 required=1", p);
        end
    endtask

    function automatic logic [31:0] rand_pkt();
        logic [31:0] p;
        p = $urandom;
        p[8:4]   = 5'($urandom_range(0, 3));
        p[13:9]  = 5'($urandom_range(0, 3));
        p[24:20] = 5'($urandom_range(0, 3));
        p[29:25] = 5'($urandom_range(0, 3));
        return p;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        iRst = 1;
        sif.iFetchValid = 0;
        sif.iFetchPacket = '0;
        dir_stall = 0;
        dir_taken = 0;
        rnd_en = 0;
        idle(3);
        iRst = 0;

        // Dual, no hazard; then slot 2 reading r1 written by slot 1
        offer(32'h0A41_8611);
        idle(3);
        offer(32'h0241_8611);
        idle(4);

        // Single BEQ taken, next packet offered straight away
        dir_taken = 1;
        offer(32'h0000_001F);
        offer(32'h0A41_8611);
        idle(4);
        dir_taken = 0;

        // Dual with slot 1 LDA, slot 2 ADDR; and BEQ dual not taken
        offer(32'h0A41_8029);
        idle(5);
        offer(32'h0A41_801F);
        idle(5);

        // JMP dual: slot 2 discarded
        offer(32'h0A41_801E);
        idle(3);

        // Stall during the first cycle of a hazard packet, fetch offered meanwhile
        offer(32'h0241_8611);
        dir_stall = 1;
        sif.iFetchPacket = 32'h0A41_8611;
        sif.iFetchValid = 1;
        idle(3);
        dir_stall = 0;
        sif.iFetchValid = 0;
        idle(4);

        // Back-to-back no-hazard duals, reset while packet 3 is resident
        offer(32'h0A41_8611);
        offer(32'h0C62_8A21);
        offer(32'h0E83_8C31);
        iRst = 1;
        idle(1);
        iRst = 0;
        offer(32'h0A41_8611);
        idle(4);

        // Randomized packets with random stalls and branch results
        rnd_en = 1;
        for (int i = 0; i < 300; i++) begin
            offer(rand_pkt());
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        rnd_en = 0;
        idle(10);
        chk("scoreboard_drained", {63'd0, cur_valid} + 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
